// File: rtl/seqpu_memio.sv
// seqpu_memio: zero-wait SRAM-style responder with RAM, GPIO, TX FIFO and status page.
// Optional free-running timer at 0xFF04 is enabled by defining SEQPU_MEMIO_TIMER_EN.
module seqpu_memio #(
  parameter int    DEPTH      = 4096,
  parameter int    FIFO_DEPTH = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] address,
  input  logic [15:0] data_out,
  output logic [15:0] data_in,
  input  logic        wren_n,
  input  logic        oen_n,
  output logic [15:0] gpio_out,
  input  logic [15:0] gpio_in,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [15:0] A_GPIO_OUT  = 16'hFF00;
  localparam logic [15:0] A_GPIO_IN   = 16'hFF01;
  localparam logic [15:0] A_TX_DATA   = 16'hFF02;
  localparam logic [15:0] A_TX_STATUS = 16'hFF03;
  localparam logic [15:0] A_TIMER     = 16'hFF04;

  logic [15:0]   mem [DEPTH];
  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          overflow_r;
  logic [15:0]   sync1_r;
  logic [15:0]   sync2_r;
  logic [15:0]   rd_data_s;

  logic          ram_hit_s;
  logic [AW-1:0] ram_idx_s;
  logic          wr_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic          push_req_s;
  logic          push_ok_s;
  logic          pop_s;
  logic          ovf_set_s;
  logic          status_rd_s;

  assign ram_hit_s    = (32'(address) < 32'(DEPTH));
  assign ram_idx_s    = address[AW-1:0];
  assign wr_s         = !wren_n && !rst;
  assign fifo_full_s  = (count_r == CW'(FIFO_DEPTH));
  assign fifo_empty_s = (count_r == CW'(0));
  assign push_req_s   = !wren_n && (address == A_TX_DATA);
  // A simultaneous pop frees the head slot first, so a full FIFO can still accept.
  assign pop_s        = !fifo_empty_s && tx_ready;
  assign push_ok_s    = push_req_s && (!fifo_full_s || pop_s);
  assign ovf_set_s    = push_req_s && fifo_full_s && !pop_s;
  assign status_rd_s  = !oen_n && (address == A_TX_STATUS);

  assign tx_valid = !fifo_empty_s;
  assign tx_data  = fifo_mem[rd_ptr_r];
  assign data_in  = rd_data_s;

  // RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_s && ram_hit_s) mem[ram_idx_s] <= data_out;
  end

  // GPIO output register and two-flop input synchronizer
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out <= 16'h0000;
      sync1_r  <= 16'h0000;
      sync2_r  <= 16'h0000;
    end else begin
      if (wr_s && (address == A_GPIO_OUT)) gpio_out <= data_out;
      sync1_r <= gpio_in;
      sync2_r <= sync1_r;
    end
  end

  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (!rst && push_ok_s) fifo_mem[wr_ptr_r] <= data_out;
  end

  // TX FIFO pointers, occupancy and sticky overflow (set beats read-clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r   <= PW'(0);
      wr_ptr_r   <= PW'(0);
      count_r    <= CW'(0);
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)     rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (ovf_set_s)        overflow_r <= 1'b1;
      else if (status_rd_s) overflow_r <= 1'b0;
      else                  overflow_r <= overflow_r;
    end
  end

`ifdef SEQPU_MEMIO_TIMER_EN
  logic [15:0] timer_r;

  // Loaded value accounts for the write cycle, so the next read sees data_out+1
  always_ff @(posedge clk) begin
    if (rst)                                  timer_r <= 16'h0000;
    else if (wr_s && (address == A_TIMER))    timer_r <= data_out + 16'h0001;
    else                                      timer_r <= timer_r + 16'h0001;
  end
`endif

  // Combinational read mux; zero when the output enable is inactive
  always_comb begin
    rd_data_s = 16'h0000;
    if (!oen_n) begin
      if (ram_hit_s) begin
        rd_data_s = mem[ram_idx_s];
      end else begin
        case (address)
          A_GPIO_OUT:  rd_data_s = gpio_out;
          A_GPIO_IN:   rd_data_s = sync2_r;
          A_TX_DATA:   rd_data_s = 16'h0000;
          A_TX_STATUS: rd_data_s = {13'h0000, overflow_r, fifo_full_s, fifo_empty_s};
`ifdef SEQPU_MEMIO_TIMER_EN
          A_TIMER:     rd_data_s = timer_r;
`endif
          default:     rd_data_s = 16'h0000;
        endcase
      end
    end else begin
      rd_data_s = 16'h0000;
    end
  end

endmodule

// File: tb/tb_seqpu_memio.sv
// Directed self-checking bench for seqpu_memio (default parameters).
module tb_seqpu_memio;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] address;
  logic [15:0] data_out;
  logic [15:0] data_in;
  logic        wren_n;
  logic        oen_n;
  logic [15:0] gpio_out;
  logic [15:0] gpio_in;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int vecs = 0;
  int errs = 0;

  seqpu_memio dut (
    .clk(clk), .rst(rst), .address(address), .data_out(data_out), .data_in(data_in),
    .wren_n(wren_n), .oen_n(oen_n), .gpio_out(gpio_out), .gpio_in(gpio_in),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    address = a; data_out = d; wren_n = 1'b0; oen_n = 1'b1;
    tick();
    wren_n = 1'b1;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    address = a; oen_n = 1'b0; wren_n = 1'b1;
    #1;
    d = data_in;
    tick();
    oen_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    rst = 1'b1;
    repeat (2) tick();
    vecs++; if (gpio_out !== 16'h0000) begin errs++; $display("FAIL rst_gpio act=%h exp=0000", gpio_out); end
    vecs++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL rst_tx_valid act=%b exp=0", tx_valid); end
    vecs++; if (data_in !== 16'h0000) begin errs++; $display("FAIL oen_off act=%h exp=0000", data_in); end
    rst = 1'b0;
    bus_read(16'hFF03, d);
    vecs++; if (d !== 16'h0001) begin errs++; $display("FAIL rst_status act=%h exp=0001", d); end
  endtask

  task automatic test_ram();
    logic [15:0] d;
    bus_write(16'h0010, 16'h1234);
    bus_read(16'h0010, d);
    vecs++; if (d !== 16'h1234) begin errs++; $display("FAIL ram_0010 act=%h exp=1234", d); end
    bus_write(16'h0011, 16'hBEEF);
    bus_read(16'h0011, d);
    vecs++; if (d !== 16'hBEEF) begin errs++; $display("FAIL ram_0011 act=%h exp=BEEF", d); end
    // address 0x1010 lies outside RAM and must not alias onto 0x0010
    bus_write(16'h1010, 16'hDEAD);
    bus_read(16'h0010, d);
    vecs++; if (d !== 16'h1234) begin errs++; $display("FAIL ram_alias act=%h exp=1234", d); end
    bus_read(16'h1000, d);
    vecs++; if (d !== 16'h0000) begin errs++; $display("FAIL ram_past_end act=%h exp=0000", d); end
    bus_read(16'hFF05, d);
    vecs++; if (d !== 16'h0000) begin errs++; $display("FAIL unmapped act=%h exp=0000", d); end
    // write and read together: data_in shows the old word
    bus_write(16'h0030, 16'h2222);
    address = 16'h0030; data_out = 16'h1111; wren_n = 1'b0; oen_n = 1'b0;
    #1;
    vecs++; if (data_in !== 16'h2222) begin errs++; $display("FAIL rw_both_pre act=%h exp=2222", data_in); end
    tick();
    wren_n = 1'b1; oen_n = 1'b1;
    bus_read(16'h0030, d);
    vecs++; if (d !== 16'h1111) begin errs++; $display("FAIL rw_both_post act=%h exp=1111", d); end
  endtask

  task automatic test_gpio();
    logic [15:0] d;
    bus_write(16'hFF00, 16'hA5A5);
    vecs++; if (gpio_out !== 16'hA5A5) begin errs++; $display("FAIL gpio_out act=%h exp=A5A5", gpio_out); end
    bus_read(16'hFF00, d);
    vecs++; if (d !== 16'hA5A5) begin errs++; $display("FAIL gpio_out_rd act=%h exp=A5A5", d); end
    gpio_in = 16'h00FF;
    address = 16'hFF01; oen_n = 1'b0;
    tick();
    vecs++; if (data_in !== 16'h0000) begin errs++; $display("FAIL gpio_in_1edge act=%h exp=0000", data_in); end
    tick();
    vecs++; if (data_in !== 16'h00FF) begin errs++; $display("FAIL gpio_in_2edge act=%h exp=00FF", data_in); end
    oen_n = 1'b1;
  endtask

  task automatic test_fifo();
    logic [15:0] d;
    tx_ready = 1'b0;
    for (int k = 1; k <= 4; k++) bus_write(16'hFF02, 16'(k));
    bus_read(16'hFF03, d);
    vecs++; if (d !== 16'h0002) begin errs++; $display("FAIL fifo_full_st act=%h exp=0002", d); end
    bus_read(16'hFF02, d);
    vecs++; if (d !== 16'h0000) begin errs++; $display("FAIL txdata_rd act=%h exp=0000", d); end
    bus_write(16'hFF02, 16'h0005);
    bus_read(16'hFF03, d);
    vecs++; if (d !== 16'h0006) begin errs++; $display("FAIL fifo_ovf_st act=%h exp=0006", d); end
    bus_read(16'hFF03, d);
    vecs++; if (d !== 16'h0002) begin errs++; $display("FAIL ovf_clear act=%h exp=0002", d); end
    vecs++; if (tx_data !== 16'h0001) begin errs++; $display("FAIL head_stable act=%h exp=0001", tx_data); end
    tx_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      vecs++;
      if (tx_valid !== 1'b1 || tx_data !== 16'(k)) begin
        errs++; $display("FAIL drain_%0d act=%b/%h exp=1/%h", k, tx_valid, tx_data, 16'(k));
      end
      tick();
    end
    tx_ready = 1'b0;
    vecs++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL drain_empty act=%b exp=0", tx_valid); end
    bus_read(16'hFF03, d);
    vecs++; if (d !== 16'h0001) begin errs++; $display("FAIL drain_st act=%h exp=0001", d); end
  endtask

  task automatic test_simultaneous();
    logic [15:0] d;
    logic [15:0] exp_q [4];
    exp_q = '{16'h0002, 16'h0003, 16'h0004, 16'h0009};
    tx_ready = 1'b0;
    for (int k = 1; k <= 4; k++) bus_write(16'hFF02, 16'(k));
    tx_ready = 1'b1;
    bus_write(16'hFF02, 16'h0009);
    tx_ready = 1'b0;
    bus_read(16'hFF03, d);
    vecs++; if (d !== 16'h0002) begin errs++; $display("FAIL simul_st act=%h exp=0002", d); end
    tx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vecs++;
      if (tx_valid !== 1'b1 || tx_data !== exp_q[k]) begin
        errs++; $display("FAIL simul_drain_%0d act=%b/%h exp=1/%h", k, tx_valid, tx_data, exp_q[k]);
      end
      tick();
    end
    tx_ready = 1'b0;
    vecs++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL simul_empty act=%b exp=0", tx_valid); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    bus_write(16'h0020, 16'h5A5A);
    bus_write(16'hFF00, 16'hFFFF);
    bus_write(16'hFF02, 16'h00AA);
    bus_write(16'hFF02, 16'h00BB);
    rst = 1'b1; address = 16'hFF02; data_out = 16'h0077; wren_n = 1'b0;
    tick();
    rst = 1'b0; wren_n = 1'b1;
    vecs++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL midrst_valid act=%b exp=0", tx_valid); end
    vecs++; if (gpio_out !== 16'h0000) begin errs++; $display("FAIL midrst_gpio act=%h exp=0000", gpio_out); end
    bus_read(16'hFF03, d);
    vecs++; if (d !== 16'h0001) begin errs++; $display("FAIL midrst_st act=%h exp=0001", d); end
    bus_read(16'h0020, d);
    vecs++; if (d !== 16'h5A5A) begin errs++; $display("FAIL midrst_ram act=%h exp=5A5A", d); end
  endtask

  task automatic test_timer();
`ifdef SEQPU_MEMIO_TIMER_EN
    logic [15:0] exp_t [3];
    exp_t = '{16'hFFFF, 16'h0000, 16'h0001};
    bus_write(16'hFF04, 16'hFFFE);
    address = 16'hFF04; oen_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      vecs++; if (data_in !== exp_t[k]) begin errs++; $display("FAIL timer_%0d act=%h exp=%h", k, data_in, exp_t[k]); end
      tick();
    end
    oen_n = 1'b1;
`else
    logic [15:0] d;
    bus_write(16'hFF04, 16'hFFFE);
    bus_read(16'hFF04, d);
    vecs++; if (d !== 16'h0000) begin errs++; $display("FAIL timer_off act=%h exp=0000", d); end
`endif
  endtask

  initial begin
    rst = 1'b1; address = 16'h0000; data_out = 16'h0000;
    wren_n = 1'b1; oen_n = 1'b1; gpio_in = 16'h0000; tx_ready = 1'b0;
    test_reset();
    test_ram();
    test_gpio();
    test_fifo();
    test_simultaneous();
    test_reset_mid();
    test_timer();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
